core_done_monitor: RTL and testbench



---
 rtl/core_done_monitor.sv | 122 ++++++++++++
 tb/tb_core_done_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_done_monitor.sv
// rtl/core_done_monitor.sv - per-core end_op latch, timestamping, done pulse and watchdog
module core_done_monitor #(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 32,
    parameter int TIMEOUT   = 2000000,
    parameter int SEL_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SEL_W-1:0]     core_sel,
    input  logic [NUM_CORES-1:0] end_op,
    input  logic [SEL_W-1:0]     rd_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [NUM_CORES-1:0] finished,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     rd_stamp
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, TMO} state_e;

    state_e               state_q, state_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic [NUM_CORES-1:0] fin_q, fin_d;
    logic [NUM_CORES-1:0] new_fin;
    logic [NUM_CORES-1:0] sel_mask;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0]     stamp_q [NUM_CORES];
    logic [CNT_W-1:0]     stamp_d [NUM_CORES];
    logic                 done_q, done_d;
    int                   sel_int;

    // Oversized core_sel values clamp to the last core.
    always_comb begin
        sel_int = int'(core_sel);
        if (sel_int > NUM_CORES - 1) begin
            sel_int = NUM_CORES - 1;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            sel_mask[i] = (i <= sel_int);
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        fin_d   = fin_q;
        cnt_d   = cnt_q;
        stamp_d = stamp_q;
        done_d  = 1'b0;
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        new_fin = end_op & mask_q & ~fin_q;
        case (state_q)
            RUN: begin
                cnt_d = cnt_inc;
                fin_d = fin_q | new_fin;
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (new_fin[i]) begin
                        stamp_d[i] = cnt_inc;
                    end
                end
                // Completion takes priority over a watchdog expiring on the same edge.
                if (((fin_q | new_fin) & mask_q) == mask_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
                    state_d = TMO;
                end
            end
            IDLE, DONE, TMO: begin
                if (start) begin
                    state_d = RUN;
                    mask_d  = sel_mask;
                    fin_d   = '0;
                    cnt_d   = '0;
                    for (int i = 0; i < NUM_CORES; i++) begin
                        stamp_d[i] = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            fin_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                stamp_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            fin_q   <= fin_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            for (int i = 0; i < NUM_CORES; i++) begin
                stamp_q[i] <= stamp_d[i];
            end
        end
    end

    always_comb begin
        rd_stamp = '0;
        if (int'(rd_idx) < NUM_CORES) begin
            rd_stamp = stamp_q[rd_idx];
        end
    end

    assign busy        = (state_q == RUN);
    assign timeout     = (state_q == TMO);
    assign done        = done_q;
    assign finished    = fin_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_core_done_monitor.sv
// tb/tb_core_done_monitor.sv - randomized scoreboard bench for core_done_monitor
module tb_core_done_monitor;

    localparam int TMO_T = 50;
    localparam int NEVER = 1000;

    typedef struct packed {
        bit                tmo;
        logic [31:0]       cnt;
        logic [3:0][31:0]  stamp;
        logic [3:0]        fin;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  core_sel;
    logic [3:0]  end_op;
    logic [1:0]  rd_idx;
    logic        busy, done, timeout;
    logic [3:0]  finished;
    logic [31:0] cycle_count, rd_stamp;

    logic        s3_start;
    logic [1:0]  s3_sel;
    logic [2:0]  s3_end;
    logic [1:0]  s3_rd;
    logic        s3_busy, s3_done, s3_timeout;
    logic [2:0]  s3_fin;
    logic [15:0] s3_cnt, s3_stamp;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic prev_done = 1'b0;
    logic prev_to   = 1'b0;

    core_done_monitor #(.NUM_CORES(4), .CNT_W(32), .TIMEOUT(TMO_T)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .core_sel(core_sel),
        .end_op(end_op), .rd_idx(rd_idx), .busy(busy), .done(done),
        .timeout(timeout), .finished(finished), .cycle_count(cycle_count),
        .rd_stamp(rd_stamp)
    );

    core_done_monitor #(.NUM_CORES(3), .CNT_W(16), .TIMEOUT(0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(s3_start), .core_sel(s3_sel),
        .end_op(s3_end), .rd_idx(s3_rd), .busy(s3_busy), .done(s3_done),
        .timeout(s3_timeout), .finished(s3_fin), .cycle_count(s3_cnt),
        .rd_stamp(s3_stamp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference outcome from the finish schedule: first completes at max(f) unless that exceeds the watchdog.
    function automatic exp_t model(input int sel, input logic [3:0][31:0] f);
        exp_t e;
        int   last = 0;
        e = '0;
        for (int i = 0; i <= sel; i++) begin
            if (int'(f[i]) > last) last = int'(f[i]);
        end
        e.tmo = (last > TMO_T);
        e.cnt = e.tmo ? TMO_T : last;
        for (int i = 0; i <= sel; i++) begin
            if (int'(f[i]) <= int'(e.cnt)) begin
                e.fin[i]   = 1'b1;
                e.stamp[i] = f[i];
            end
        end
        return e;
    endfunction

    task automatic run_one(input int sel, input logic [3:0][31:0] f, input int gap);
        exp_t e;
        e = model(sel, f);
        start    = 1'b1;
        core_sel = 2'(sel);
        end_op   = 4'($urandom);
        sb.push_back(e);
        @(posedge clk); #1;
        chk("arm_busy", busy, 1);
        chk("arm_count", cycle_count, 0);
        chk("arm_finished", finished, 0);
        chk("arm_timeout", timeout, 0);
        for (int n = 1; n <= int'(e.cnt); n++) begin
            for (int i = 0; i < 4; i++) begin
                if (i > sel || n > int'(f[i])) end_op[i] = 1'($urandom);
                else end_op[i] = (n == int'(f[i]));
            end
            start = ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
        end
        start  = 1'b0;
        end_op = 4'($urandom);
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) chk("done_width", prev_done, 0);
            if (done || (timeout && !prev_to)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_event: done=%0b timeout=%0b with no run pending at %0t",
                             done, timeout, $time);
                end else begin
                    e = sb.pop_front();
                    chk("end_timeout", timeout, e.tmo);
                    chk("end_done", done, !e.tmo);
                    chk("end_busy", busy, 0);
                    chk("end_count", cycle_count, e.cnt);
                    chk("end_finished", finished, e.fin);
                    for (int i = 0; i < 4; i++) begin
                        rd_idx = 2'(i);
                        #1;
                        chk($sformatf("stamp%0d", i), rd_stamp, e.stamp[i]);
                    end
                end
            end
        end
        prev_done = done;
        prev_to   = timeout;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0][31:0] f;
        int               waited;
        rst_n    = 1'b0;
        start    = 1'b1;
        core_sel = 2'd3;
        end_op   = 4'hF;
        rd_idx   = 2'd0;
        s3_start = 1'b0;
        s3_sel   = 2'd0;
        s3_end   = 3'b000;
        s3_rd    = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_finished", finished, 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_stamp", rd_stamp, 0);

        // Release with start held: accepted on the first edge, all cores finish on the next.
        rst_n = 1'b1;
        sb.push_back(model(3, {32'd1, 32'd1, 32'd1, 32'd1}));
        @(posedge clk); #1;
        chk("rel_busy", busy, 1);
        chk("rel_count", cycle_count, 0);
        start = 1'b0;
        @(posedge clk); #1;
        chk("minlat_done", done, 1);
        chk("minlat_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;

        f = {32'd20, 32'd9, 32'd9, 32'd5};           run_one(3, f, 2);
        f = {NEVER, NEVER, 32'd7, 32'd3};            run_one(1, f, 1);
        f = {NEVER, 32'd7, 32'd6, 32'd5};            run_one(3, f, 0);
        f = {32'd50, 32'd30, 32'd20, 32'd10};        run_one(3, f, 0);
        f = {32'd2, 32'd2, 32'd2, 32'd2};            run_one(2, f, 0);
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 4; i++) begin
                f[i] = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(1, 55);
            end
            run_one($urandom_range(0, 3), f, $urandom_range(0, 2));
        end

        // Reset mid-run clears asynchronously and never yields done.
        start    = 1'b1;
        core_sel = 2'd3;
        end_op   = 4'h0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_count_before", cycle_count, 10);
        rst_n  = 1'b0;
        end_op = 4'hF;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_count", cycle_count, 0);
        chk("mid_finished", finished, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 0);

        // Three-core instance: core_sel=3 clamps to all three cores.
        s3_start = 1'b1;
        s3_sel   = 2'd3;
        @(posedge clk); #1;
        s3_start = 1'b0;
        s3_end   = 3'b011;
        @(posedge clk); #1;
        s3_end = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk("s3_wait_busy", s3_busy, 1);
        s3_end = 3'b100;
        waited = 0;
        while (!s3_done && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("s3_done", s3_done, 1);
        chk("s3_finished", s3_fin, 3'b111);
        chk("s3_count", s3_cnt, 4);
        s3_rd = 2'd0; #1; chk("s3_stamp0", s3_stamp, 1);
        s3_rd = 2'd2; #1; chk("s3_stamp2", s3_stamp, 4);
        s3_rd = 2'd3; #1; chk("s3_stamp_oob", s3_stamp, 0);
        chk("s3_timeout", s3_timeout, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
